// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared image-kernel package
// Window geometry helpers and frame-buffer state shared by the edge kernels.
package img_pkg;

  typedef enum logic [1:0] {
    FB_CLEAR = 2'd0,
    FB_LOAD  = 2'd1,
    FB_FULL  = 2'd2
  } fb_state_e;

  function automatic int win_ctr(input int n);
    return n / 2;
  endfunction

  localparam int IMG_WIN_WD = 3;
  localparam int IMG_WIN_HT = 3;
  localparam int IMG_WIN_CX = IMG_WIN_WD / 2;
  localparam int IMG_WIN_CY = IMG_WIN_HT / 2;

  // Bit offset of window element [j][i] in a row-major flattened window.
  function automatic int win_ofs(input int j, input int i, input int win_wd, input int pxl_bits);
    return (j * win_wd + i) * pxl_bits;
  endfunction

endpackage

// File: rtl/frame_buf_win_if.sv
// rtl/frame_buf_win_if.sv - kernel-side read/write/load bus of the frame buffer
// master is the kernel/loader side, slave is the buffer.
interface frame_buf_win_if #(
  parameter int COORD_BITS = 4,
  parameter int PXL_BITS   = 12,
  parameter int WIN_WD     = 3,
  parameter int WIN_HT     = 3
);
  logic                                rd_en;
  logic [COORD_BITS-1:0]               rd_x;
  logic [COORD_BITS-1:0]               rd_y;
  logic [WIN_HT*WIN_WD*PXL_BITS-1:0]   rd_data_flat;
  logic                                wr_en;
  logic [COORD_BITS-1:0]               wr_x;
  logic [COORD_BITS-1:0]               wr_y;
  logic signed [PXL_BITS-1:0]          wr_data_pxl;
  logic                                ld_valid;
  logic                                ld_ready;
  logic signed [PXL_BITS-1:0]          ld_pxl;
  logic                                ld_last;
  logic                                frame_loaded;
  logic                                ld_err;

  modport master (
    output rd_en, rd_x, rd_y,
    input  rd_data_flat,
    output wr_en, wr_x, wr_y, wr_data_pxl,
    output ld_valid, ld_pxl, ld_last,
    input  ld_ready, frame_loaded, ld_err
  );

  modport slave (
    input  rd_en, rd_x, rd_y,
    output rd_data_flat,
    input  wr_en, wr_x, wr_y, wr_data_pxl,
    input  ld_valid, ld_pxl, ld_last,
    output ld_ready, frame_loaded, ld_err
  );
endinterface

// File: rtl/fb_win_gather.sv
// rtl/fb_win_gather.sv - combinational window assembly with zero padding
// Picks a WIN_HT x WIN_WD neighbourhood around (rd_x, rd_y) out of the flat pixel array.
module fb_win_gather
  import img_pkg::*;
#(
  parameter int IMG_WD     = 16,
  parameter int IMG_HT     = 16,
  parameter int COORD_BITS = 4,
  parameter int WIN_WD     = 3,
  parameter int WIN_HT     = 3,
  parameter int PXL_BITS   = 12
) (
  input  logic                                  rd_en,
  input  logic [COORD_BITS-1:0]                 rd_x,
  input  logic [COORD_BITS-1:0]                 rd_y,
  input  logic [IMG_WD*IMG_HT*PXL_BITS-1:0]     pix_flat,
  output logic [WIN_HT*WIN_WD*PXL_BITS-1:0]     rd_data_flat
);
  localparam int CW     = COORD_BITS + 2;
  localparam int PIX_IW = $clog2(IMG_WD * IMG_HT * PXL_BITS);
  localparam int OUT_IW = $clog2(WIN_WD * WIN_HT * PXL_BITS);

  logic signed [CW-1:0] cx;
  logic signed [CW-1:0] cy;
  int                   cxi;
  int                   cyi;
  logic [PIX_IW-1:0]    pix_base;
  logic [OUT_IW-1:0]    out_base;

  always_comb begin
    rd_data_flat = '0;
    cx           = '0;
    cy           = '0;
    cxi          = 0;
    cyi          = 0;
    pix_base     = '0;
    out_base     = '0;
    if (rd_en) begin
      for (int j = 0; j < WIN_HT; j++) begin
        for (int i = 0; i < WIN_WD; i++) begin
          // Two extra bits keep off-image coordinates negative or above range instead of wrapping.
          cx  = $signed({2'b00, rd_x}) + $signed(CW'(i - win_ctr(WIN_WD)));
          cy  = $signed({2'b00, rd_y}) + $signed(CW'(j - win_ctr(WIN_HT)));
          cxi = int'(cx);
          cyi = int'(cy);
          if (cxi >= 0 && cxi < IMG_WD && cyi >= 0 && cyi < IMG_HT) begin
            pix_base = PIX_IW'((cyi * IMG_WD + cxi) * PXL_BITS);
            out_base = OUT_IW'(win_ofs(j, i, WIN_WD, PXL_BITS));
            rd_data_flat[out_base +: PXL_BITS] = pix_flat[pix_base +: PXL_BITS];
          end
        end
      end
    end
  end

endmodule

// File: rtl/frame_buf_win.sv
// rtl/frame_buf_win.sv - windowed frame buffer with raster load port and self-clear
// Holds the pixel storage, clear/load/full sequencing and the write arbitration.
module frame_buf_win
  import img_pkg::*;
#(
  parameter int IMG_WD     = 16,
  parameter int IMG_HT     = 16,
  parameter int COORD_BITS = 4,
  parameter int WIN_WD     = 3,
  parameter int WIN_HT     = 3,
  parameter int PXL_BITS   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  output logic               busy,
  frame_buf_win_if.slave     bus
);
  localparam int NPIX = IMG_WD * IMG_HT;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  fb_state_e             state_q, state_d;
  logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
  logic [COORD_BITS-1:0] ld_x_q, ld_x_d;
  logic [COORD_BITS-1:0] ld_y_q, ld_y_d;
  logic                  frame_loaded_q, frame_loaded_d;
  logic                  ld_err_q, ld_err_d;

  logic                       ld_fire;
  logic                       ld_final;
  logic                       wr_in_range;
  logic                       mem_we;
  logic [AW-1:0]              mem_addr;
  logic signed [PXL_BITS-1:0] mem_wdata;

  logic signed [PXL_BITS-1:0]       mem_q [NPIX];
  logic [NPIX*PXL_BITS-1:0]         pix_flat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FB_CLEAR;
      clr_cnt_q      <= '0;
      ld_x_q         <= '0;
      ld_y_q         <= '0;
      frame_loaded_q <= 1'b0;
      ld_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      ld_x_q         <= ld_x_d;
      ld_y_q         <= ld_y_d;
      frame_loaded_q <= frame_loaded_d;
      ld_err_q       <= ld_err_d;
    end
  end

  // Pixel storage is deliberately unreset; the CLEAR sweep defines its contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  always_comb begin
    state_d        = state_q;
    clr_cnt_d      = clr_cnt_q;
    ld_x_d         = ld_x_q;
    ld_y_d         = ld_y_q;
    frame_loaded_d = frame_loaded_q;
    ld_err_d       = ld_err_q;
    unique case (state_q)
      FB_CLEAR: begin
        if (clr_cnt_q == AW'(NPIX - 1)) begin
          state_d   = FB_LOAD;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      FB_LOAD: begin
        if (ld_fire) begin
          if (bus.ld_last != ld_final) begin
            ld_err_d = 1'b1;
          end
          if (ld_final) begin
            state_d        = FB_FULL;
            frame_loaded_d = 1'b1;
          end else if (ld_x_q == COORD_BITS'(IMG_WD - 1)) begin
            ld_x_d = '0;
            ld_y_d = ld_y_q + 1'b1;
          end else begin
            ld_x_d = ld_x_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (clr) begin
      state_d        = FB_CLEAR;
      clr_cnt_d      = '0;
      ld_x_d         = '0;
      ld_y_d         = '0;
      frame_loaded_d = 1'b0;
      ld_err_d       = 1'b0;
    end
  end

  always_comb begin
    busy             = (state_q == FB_CLEAR);
    bus.ld_ready     = (state_q == FB_LOAD) && !bus.wr_en;
    bus.frame_loaded = frame_loaded_q;
    bus.ld_err       = ld_err_q;
    ld_fire          = bus.ld_valid && bus.ld_ready;
    ld_final         = (ld_x_q == COORD_BITS'(IMG_WD - 1)) && (ld_y_q == COORD_BITS'(IMG_HT - 1));
    wr_in_range      = (int'(bus.wr_x) < IMG_WD) && (int'(bus.wr_y) < IMG_HT);
    mem_we           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    if (state_q == FB_CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_cnt_q;
    end else if (bus.wr_en && wr_in_range) begin
      mem_we    = 1'b1;
      mem_addr  = AW'(int'(bus.wr_y) * IMG_WD + int'(bus.wr_x));
      mem_wdata = bus.wr_data_pxl;
    end else if (ld_fire) begin
      mem_we    = 1'b1;
      mem_addr  = AW'(int'(ld_y_q) * IMG_WD + int'(ld_x_q));
      mem_wdata = bus.ld_pxl;
    end
  end

  for (genvar p = 0; p < NPIX; p++) begin : g_flat
    assign pix_flat[p*PXL_BITS +: PXL_BITS] = mem_q[p];
  end

  fb_win_gather #(
    .IMG_WD     (IMG_WD),
    .IMG_HT     (IMG_HT),
    .COORD_BITS (COORD_BITS),
    .WIN_WD     (WIN_WD),
    .WIN_HT     (WIN_HT),
    .PXL_BITS   (PXL_BITS)
  ) u_gather (
    .rd_en        (bus.rd_en),
    .rd_x         (bus.rd_x),
    .rd_y         (bus.rd_y),
    .pix_flat     (pix_flat),
    .rd_data_flat (bus.rd_data_flat)
  );

endmodule

// File: doc/frame_buf_win.md
Name: frame_buf_win

Overview:
Windowed frame buffer. It serves as the source and destination memory for the per-pixel image kernels in the edge-detector pipeline. It answers a kernel's zero-latency window read (rd_en/rd_x/rd_y → rd_data_flat) and accepts its per-pixel writes (wr_en/wr_x/wr_y/wr_data_pxl). It also takes a raster-order streaming load port for the initial image, and self-clears after reset or on request.

Parameters:
IMG_WD, 16, image width in pixels
IMG_HT, 16, image height in pixels
COORD_BITS, 4, bits to address any X or Y coordinate (≥ clog2 of max(IMG_WD, IMG_HT))
WIN_WD, 3, read window width (odd)
WIN_HT, 3, read window height (odd)
PXL_BITS, 12, signed pixel width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
clr  in  1  one-cycle request: zero all pixels, restart load
busy  out  1  high while clearing
rd_en  in  1  window read enable
rd_x  in  COORD_BITS  window centre X
rd_y  in  COORD_BITS  window centre Y
rd_data_flat  out  WIN_HT*WIN_WD*PXL_BITS  flattened window
wr_en  in  1  pixel write enable
wr_x  in  COORD_BITS  write X
wr_y  in  COORD_BITS  write Y
wr_data_pxl  in  PXL_BITS (signed)  write data
ld_valid  in  1  load pixel valid
ld_ready  out  1  load pixel accepted this cycle if ld_valid
ld_pxl  in  PXL_BITS (signed)  load pixel, raster order
ld_last  in  1  marks final pixel of frame
frame_loaded  out  1  full frame received via load port
ld_err  out  1  sticky: ld_last misplaced

Behaviour:
- States: CLEAR, LOAD, FULL.
- Reset: state=CLEAR, clear counter=0, load counter=0, busy=1, ld_ready=0, frame_loaded=0, ld_err=0. Memory contents are not reset; CLEAR defines them.
- CLEAR:
  - Writes 0 to one pixel per cycle, in raster order.
  - After IMG_WD*IMG_HT cycles, goes to LOAD with busy=0.
  - wr_en and ld_valid are ignored; ld_ready=0.
- LOAD:
  - ld_ready = ~wr_en.
  - On ld_valid&ld_ready, writes ld_pxl at the load counter's (x,y); x wraps at IMG_WD−1 and increments y.
  - On the final pixel (x=IMG_WD−1, y=IMG_HT−1): go to FULL and set frame_loaded=1.
  - ld_err is set if ld_last≠(pixel is final) on any accepted beat.
- FULL: ld_ready=0; frame_loaded stays 1.
- clr in any state: next state CLEAR; counters=0; frame_loaded=0; ld_err=0; busy=1 from the next cycle. A clr during CLEAR restarts the sweep.
- Write port:
  - Active in LOAD and FULL.
  - Takes priority over the load port in the same cycle; the load beat is stalled, not dropped.
  - Writes with wr_x≥IMG_WD or wr_y≥IMG_HT are ignored.
  - Memory updates at the rising edge.
- Read port:
  - Combinational, zero latency, read-before-write: returns memory contents as of the start of the cycle, so a kernel reading and writing the same buffer sees pre-write data.
  - Window element [j][i] is at bit offset (j*WIN_WD+i)*PXL_BITS. It holds pixel (rd_x+i−WIN_WD/2, rd_y+j−WIN_HT/2).
  - Coordinates are computed signed at COORD_BITS+2 bits; any coordinate <0 or ≥ image size reads 0 (zero padding).
  - rd_en=0 gives rd_data_flat=0.
  - Reads are valid in every state; during CLEAR they return partially cleared data.
- Storage: one PXL_BITS-wide register per pixel, addressed y*IMG_WD+x.

Decomposition:
- Shared package img_pkg: window-centre constants (WIN_WD/2, WIN_HT/2), a flat-offset function (j,i)→bit offset, and the frame-buffer state enum. The edge kernels reuse all three.
- One sub-module, fb_win_gather: purely combinational window assembly with zero padding from the pixel array. The top level holds the FSM, counters and storage.

Test Plan (IMG_WD=4, IMG_HT=3, WIN 3x3, PXL_BITS=8):
- Release reset → busy=1 for exactly 12 cycles, then busy=0 and ld_ready=1. Read at (1,1) → all nine elements 0.
- Stream 0x01..0x0C with ld_last on the 12th beat → frame_loaded=1 the cycle after beat 12, ld_ready=0, ld_err=0. Read (1,1) → rows {01,02,03},{05,06,07},{09,0A,0B}.
- Read corner (0,0) after load → row 0 all 0, element [1][0]=0, [1][1]=01, [2][2]=06. Read (3,2) → column 2 and row 2 all 0.
- During LOAD, assert wr_en (2,0)=0x7F alongside ld_valid → that cycle ld_ready=0 and the beat is accepted next cycle. Same-cycle read of (2,0) shows the old value; the next cycle shows 0x7F. wr to (4,0) has no effect.
- Assert ld_last on beat 5 → ld_err=1 and stays set until clr. Load continues to beat 12.
- Assert clr while FULL, then rst_n low mid-CLEAR → busy=1, frame_loaded=0. After reset release, a full 12-cycle sweep completes, then all reads return 0.
